// File: rtl/lr_dp_mem_pkg.sv
// lr_dp_mem_pkg: shared constants, FSM state encoding and the lane-reverse
// helper for the LR data-point memory.
package lr_dp_mem_pkg;

  localparam int MAX_FEATURES = 6;
  localparam int LANE_W       = 16;
  localparam int NUM_LANES    = MAX_FEATURES + 1;
  localparam int ROW_W        = NUM_LANES * LANE_W;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    SERVE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // The trainer drives its weights MSB-lane first; row 0 stores them LSB-lane
  // first. Lane j moves to lane NUM_LANES-1-j.
  function automatic logic [ROW_W-1:0] lane_rev(input logic [ROW_W-1:0] r);
    logic [ROW_W-1:0] o;
    o = '0;
    for (int j = 0; j < NUM_LANES; j++)
      o[LANE_W*(NUM_LANES-1-j) +: LANE_W] = r[LANE_W*j +: LANE_W];
    return o;
  endfunction

endpackage

// File: rtl/lr_dp_mem_if.sv
// lr_dp_mem_if: host load port (valid/ready write of one row per handshake).
// master = host side, slave = memory block side.
interface lr_dp_mem_if #(
  parameter int DP_BITS = 4
) ();
  import lr_dp_mem_pkg::*;

  logic                ld_valid;
  logic                ld_ready;
  logic [DP_BITS-1:0]  ld_addr;
  logic [ROW_W-1:0]    ld_data;

  modport master (output ld_valid, ld_addr, ld_data, input ld_ready);
  modport slave  (input ld_valid, ld_addr, ld_data, output ld_ready);

endinterface

// File: rtl/lr_row_ram.sv
// lr_row_ram: DEPTH rows x ROW_W, one synchronous write port and one
// asynchronous read port. Contents have no reset.
module lr_row_ram
  import lr_dp_mem_pkg::*;
#(
  parameter int DEPTH = 7,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [ROW_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [ROW_W-1:0] rdata
);

  localparam int            IW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [ROW_W-1:0] mem [DEPTH];

  // Row write; addresses past the last row are dropped so a truncated index
  // can never alias onto a valid row.
  always_ff @(posedge clk) begin
    if (we && (waddr <= LAST))
      mem[waddr[IW-1:0]] <= wdata;
  end

  // Out-of-range reads return zero.
  assign rdata = (raddr <= LAST) ? mem[raddr[IW-1:0]] : '0;

endmodule

// File: rtl/lr_dp_mem.sv
// lr_dp_mem: data-point memory and weight store for the LR trainer.
// Host loads rows over the ld port, the block serves rows on the shared
// bidirectional bus temp, then captures the trained weights when the trainer
// raises fin_final and writes them back to row 0.
// Optional feature: define LR_DP_MEM_BOUNDS_CHECK_EN to add a sticky err
// output flagging out-of-range loads and reads.
module lr_dp_mem
  import lr_dp_mem_pkg::*;
#(
  parameter int DPS     = 6,
  parameter int DP_BITS = 4
) (
  input  logic               CLK,
  input  logic               RST,
  lr_dp_mem_if.slave         ld,
  input  logic               start,
  input  logic [DP_BITS-1:0] addr,
  input  logic               fin_final,
  inout  wire  [ROW_W-1:0]   temp,
  output logic [ROW_W-1:0]   wt_out,
  output logic               wt_valid,
  output logic               busy
`ifdef LR_DP_MEM_BOUNDS_CHECK_EN
  ,
  output logic               err
`endif
);

  localparam logic [DP_BITS-1:0] DPS_A = DP_BITS'(DPS);

  state_e state, nstate;

  logic               ld_hs;
  logic               ld_in_rng;
  logic               ld_we;
  logic               ram_we;
  logic [DP_BITS-1:0] ram_waddr;
  logic [ROW_W-1:0]   ram_wdata;
  logic [ROW_W-1:0]   rd_row;
  logic [ROW_W-1:0]   cap_row;
  logic               drv;

  assign ld.ld_ready = (state == LOAD) || (state == DONE);
  assign ld_hs       = ld.ld_valid && ld.ld_ready;
  assign ld_in_rng   = (ld.ld_addr <= DPS_A);
  // A handshake in DONE only returns to LOAD; its word is discarded.
  assign ld_we       = ld_hs && (state == LOAD) && ld_in_rng;

  assign busy     = (state == SERVE);
  assign wt_valid = (state == DONE);

  // Bus is released the same cycle the trainer asserts fin_final.
  assign drv  = (state == SERVE) && !fin_final;
  assign temp = drv ? rd_row : {ROW_W{1'bz}};

  assign cap_row = lane_rev(temp);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= LOAD;
    else     state <= nstate;
  end

  // Next-state logic; fin_final outranks start in SERVE.
  always_comb begin
    nstate = state;
    case (state)
      LOAD:    if (start) nstate = SERVE;
      SERVE:   if (fin_final) nstate = CAPTURE;
      CAPTURE: nstate = DONE;
      DONE: begin
        if (start)            nstate = SERVE;
        else if (ld.ld_valid) nstate = LOAD;
      end
      default: nstate = LOAD;
    endcase
  end

  // RAM write port: capture write-back to row 0 or a host load.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ld.ld_addr;
    ram_wdata = ld.ld_data;
    if (state == CAPTURE) begin
      ram_we    = 1'b1;
      ram_waddr = '0;
      ram_wdata = cap_row;
    end else if (ld_we) begin
      ram_we    = 1'b1;
    end
  end

  // Captured weights, held until the next capture or reset.
  always_ff @(posedge CLK) begin
    if (RST)                   wt_out <= '0;
    else if (state == CAPTURE) wt_out <= cap_row;
  end

`ifdef LR_DP_MEM_BOUNDS_CHECK_EN
  // Sticky range error: out-of-range SERVE read or LOAD write attempt.
  always_ff @(posedge CLK) begin
    if (RST)
      err <= 1'b0;
    else if (((state == SERVE) && (addr > DPS_A)) ||
             (ld_hs && (state == LOAD) && !ld_in_rng))
      err <= 1'b1;
  end
`endif

  lr_row_ram #(
    .DEPTH (DPS + 1),
    .AW    (DP_BITS)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (addr),
    .rdata (rd_row)
  );

endmodule

// File: tb/tb_lr_dp_mem.sv
// tb_lr_dp_mem: directed self-checking bench for lr_dp_mem.
// Inputs change at the falling edge; outputs are checked 1 time unit later.
// To see a released bus, the bench drives zero onto temp and expects zero.
module tb_lr_dp_mem;
  import lr_dp_mem_pkg::*;

  localparam int DPS     = 6;
  localparam int DP_BITS = 4;

  localparam logic [ROW_W-1:0] PAT_A = 112'h0011_0022_0033_0044_0055_0066_0077;
  localparam logic [ROW_W-1:0] REV_A = 112'h0077_0066_0055_0044_0033_0022_0011;
  localparam logic [ROW_W-1:0] PAT_B = 112'h0101_0202_0303_0404_0505_0606_0707;
  localparam logic [ROW_W-1:0] REV_B = 112'h0707_0606_0505_0404_0303_0202_0101;

  logic               CLK = 1'b0;
  logic               RST;
  logic               start;
  logic [DP_BITS-1:0] addr;
  logic               fin_final;
  wire  [ROW_W-1:0]   temp;
  logic [ROW_W-1:0]   wt_out;
  logic               wt_valid;
  logic               busy;
`ifdef LR_DP_MEM_BOUNDS_CHECK_EN
  logic               err;
`endif

  logic             tb_en;
  logic [ROW_W-1:0] tb_val;
  logic [ROW_W-1:0] row_exp [DPS+1];

  int n_cmp = 0;
  int n_err = 0;

  assign temp = tb_en ? tb_val : {ROW_W{1'bz}};

  always #5 CLK = ~CLK;

  lr_dp_mem_if #(.DP_BITS(DP_BITS)) ld_if ();

  lr_dp_mem #(
    .DPS     (DPS),
    .DP_BITS (DP_BITS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ld        (ld_if),
    .start     (start),
    .addr      (addr),
    .fin_final (fin_final),
    .temp      (temp),
    .wt_out    (wt_out),
    .wt_valid  (wt_valid),
    .busy      (busy)
`ifdef LR_DP_MEM_BOUNDS_CHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic chk(input string tag, input logic [ROW_W-1:0] got,
                     input logic [ROW_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    row_exp[0] = {7{16'h0040}};
    row_exp[1] = 112'h0600_0300_0400_0200_0100_0500_0200;
    row_exp[2] = {7{16'h0202}};
    row_exp[3] = {7{16'h0303}};
    row_exp[4] = {7{16'h0404}};
    row_exp[5] = {7{16'h0505}};
    row_exp[6] = {7{16'h0606}};

    RST = 1'b1; start = 1'b0; addr = '0; fin_final = 1'b0;
    tb_en = 1'b0; tb_val = '0;
    ld_if.ld_valid = 1'b0; ld_if.ld_addr = '0; ld_if.ld_data = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_ld_ready", ld_if.ld_ready, 1'b1);
    chk("rst_busy",     busy,           1'b0);
    chk("rst_wt_valid", wt_valid,       1'b0);
    chk("rst_wt_out",   wt_out,         '0);
`ifdef LR_DP_MEM_BOUNDS_CHECK_EN
    chk("rst_err",      err,            1'b0);
`endif
    addr = 4'd1; tb_en = 1'b1; tb_val = '0; #1;
    chk("rst_bus_z", temp, '0);
    tb_en = 1'b0;

    // Load rows 0..DPS; start arrives with the last word.
    for (int k = 0; k <= DPS; k++) begin
      @(negedge CLK);
      ld_if.ld_valid = 1'b1;
      ld_if.ld_addr  = DP_BITS'(k);
      ld_if.ld_data  = row_exp[k];
      start          = (k == DPS);
    end
    @(negedge CLK);
    ld_if.ld_valid = 1'b0; start = 1'b0;
    #1;
    chk("serve_busy",     busy,           1'b1);
    chk("serve_ld_ready", ld_if.ld_ready, 1'b0);
    addr = 4'd0; #1; chk("rd_row0", temp, row_exp[0]);
    addr = 4'd1; #1; chk("rd_row1", temp, row_exp[1]);
    addr = 4'd6; #1; chk("rd_row6_start_same_cyc", temp, row_exp[6]);

    // Out-of-range reads.
    addr = 4'd7; #1; chk("rd_oor7", temp, '0);
    addr = 4'd9; #1; chk("rd_oor9", temp, '0);
    @(negedge CLK);
`ifdef LR_DP_MEM_BOUNDS_CHECK_EN
    #1; chk("err_rd_oor", err, 1'b1);
`endif

    // ld_valid held in SERVE is refused.
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = 4'd2; ld_if.ld_data = '1;
    #1; chk("serve_ld_refused", ld_if.ld_ready, 1'b0);
    @(negedge CLK);
    ld_if.ld_valid = 1'b0; addr = 4'd2;
    #1; chk("serve_no_write", temp, row_exp[2]);

    // Capture: trainer drives PAT_A, block must let go immediately.
    addr = 4'd1; fin_final = 1'b1; tb_en = 1'b1; tb_val = PAT_A;
    #1;
    chk("fin_bus_released", temp, PAT_A);
    @(negedge CLK);
    fin_final = 1'b0;
    #1;
    chk("cap_busy",     busy,     1'b0);
    chk("cap_wt_valid", wt_valid, 1'b0);
    chk("cap_bus",      temp,     PAT_A);
    @(negedge CLK);
    tb_val = '0;
    #1;
    chk("done_wt_valid", wt_valid, 1'b1);
    chk("done_wt_out",   wt_out,   REV_A);
    chk("done_bus_z",    temp,     '0);
`ifdef LR_DP_MEM_BOUNDS_CHECK_EN
    chk("err_sticky_done", err, 1'b1);
`endif
    tb_en = 1'b0;

    // New run reads the captured weights back from row 0.
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0; addr = 4'd0;
    #1;
    chk("rerun_busy", busy, 1'b1);
    chk("row0_wb_a",  temp, REV_A);

    // start and fin_final together: capture wins.
    start = 1'b1; fin_final = 1'b1; tb_en = 1'b1; tb_val = PAT_B;
    @(negedge CLK);
    start = 1'b0; fin_final = 1'b0;
    #1;
    chk("both_cap_busy",  busy,     1'b0);
    chk("both_cap_wtv",   wt_valid, 1'b0);
    @(negedge CLK);
    tb_en = 1'b0;
    #1;
    chk("both_done_wtv",  wt_valid, 1'b1);
    chk("both_wt_out",    wt_out,   REV_B);

    // ld_valid in DONE returns to LOAD without writing.
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = 4'd3; ld_if.ld_data = {7{16'hDEAD}};
    #1; chk("done_ld_ready", ld_if.ld_ready, 1'b1);
    @(negedge CLK);
    ld_if.ld_valid = 1'b0;
    #1;
    chk("load_wt_valid", wt_valid, 1'b0);
    chk("load_busy",     busy,     1'b0);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0; addr = 4'd0;
    #1; chk("row0_wb_b",  temp, REV_B);
    addr = 4'd3;
    #1; chk("done_ld_no_write", temp, row_exp[3]);

    // Reset mid-SERVE.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rstm_busy",     busy,           1'b0);
    chk("rstm_ld_ready", ld_if.ld_ready, 1'b1);
    chk("rstm_wt_valid", wt_valid,       1'b0);
`ifdef LR_DP_MEM_BOUNDS_CHECK_EN
    chk("rstm_err",      err,            1'b0);
`endif
    tb_en = 1'b1; tb_val = '0; #1;
    chk("rstm_bus_z", temp, '0);
    tb_en = 1'b0;

    // Out-of-range load must not alias onto a valid row.
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = 4'd9; ld_if.ld_data = '1;
    @(negedge CLK);
    ld_if.ld_valid = 1'b0; start = 1'b1;
`ifdef LR_DP_MEM_BOUNDS_CHECK_EN
    #1; chk("err_ld_oor", err, 1'b1);
`endif
    @(negedge CLK);
    start = 1'b0; addr = 4'd3;
    #1; chk("retain_row3", temp, row_exp[3]);
    addr = 4'd1;
    #1; chk("oor_ld_no_alias", temp, row_exp[1]);
    addr = 4'd0;
    #1; chk("retain_row0", temp, REV_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
